// File: rtl/reset_sequencer.sv
// Board reset sequencer: waits for PLL lock, stretches reset, then releases
// peripheral reset before core reset and records why the last reset happened.
module reset_sequencer #(
   parameter int HOLD_CYCLES = 16,
   parameter int CORE_DELAY  = 4
) (
   input  logic       clk_in,
   input  logic       reset_in,
   input  logic       locked_in,
   input  logic       btn_pulse_in,
   output logic       periph_reset_out,
   output logic       core_reset_out,
   output logic       reset_done_out,
   output logic [1:0] cause_out
);

   localparam int MAX_CNT = (HOLD_CYCLES > CORE_DELAY) ? HOLD_CYCLES : CORE_DELAY;
   localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_DELAY - 1);

   localparam logic [1:0] CAUSE_POR    = 2'b01;
   localparam logic [1:0] CAUSE_PLL    = 2'b10;
   localparam logic [1:0] CAUSE_BUTTON = 2'b11;

   typedef enum logic [1:0] {
      WAIT_LOCK,
      COUNT,
      PERIPH,
      RUN
   } state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             periph_reg;
   logic             core_reg;
   logic             done_reg;
   logic [1:0]       cause_reg;

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_reg  <= WAIT_LOCK;
         cnt_reg    <= '0;
         periph_reg <= 1'b1;
         core_reg   <= 1'b1;
         done_reg   <= 1'b0;
         cause_reg  <= CAUSE_POR;
      end else begin
         case (state_reg)
            WAIT_LOCK: begin
               periph_reg <= 1'b1;
               core_reg   <= 1'b1;
               done_reg   <= 1'b0;
               cnt_reg    <= '0;
               if (locked_in) begin
                  state_reg <= COUNT;
               end
            end

            COUNT: begin
               if (!locked_in) begin
                  state_reg <= WAIT_LOCK;
                  cnt_reg   <= '0;
                  cause_reg <= CAUSE_PLL;
               end else if (btn_pulse_in) begin
                  cnt_reg   <= '0;
                  cause_reg <= CAUSE_BUTTON;
               end else if (cnt_reg == HOLD_LAST) begin
                  state_reg  <= PERIPH;
                  cnt_reg    <= '0;
                  periph_reg <= 1'b0;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end

            PERIPH: begin
               // Lock loss outranks a simultaneous button press.
               if (!locked_in) begin
                  state_reg  <= WAIT_LOCK;
                  cnt_reg    <= '0;
                  periph_reg <= 1'b1;
                  core_reg   <= 1'b1;
                  cause_reg  <= CAUSE_PLL;
               end else if (btn_pulse_in) begin
                  state_reg  <= COUNT;
                  cnt_reg    <= '0;
                  periph_reg <= 1'b1;
                  core_reg   <= 1'b1;
                  cause_reg  <= CAUSE_BUTTON;
               end else if (cnt_reg == CORE_LAST) begin
                  state_reg <= RUN;
                  cnt_reg   <= '0;
                  core_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end

            RUN: begin
               if (!locked_in) begin
                  state_reg  <= WAIT_LOCK;
                  cnt_reg    <= '0;
                  periph_reg <= 1'b1;
                  core_reg   <= 1'b1;
                  done_reg   <= 1'b0;
                  cause_reg  <= CAUSE_PLL;
               end else if (btn_pulse_in) begin
                  state_reg  <= COUNT;
                  cnt_reg    <= '0;
                  periph_reg <= 1'b1;
                  core_reg   <= 1'b1;
                  done_reg   <= 1'b0;
                  cause_reg  <= CAUSE_BUTTON;
               end
            end

            default: begin
               state_reg  <= WAIT_LOCK;
               cnt_reg    <= '0;
               periph_reg <= 1'b1;
               core_reg   <= 1'b1;
               done_reg   <= 1'b0;
            end
         endcase
      end
   end

   assign periph_reset_out = periph_reg;
   assign core_reset_out   = core_reg;
   assign reset_done_out   = done_reg;
   assign cause_out        = cause_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus random traffic, checked
// against a model that tracks elapsed edges since the last sequence start.
module tb_reset_sequencer;

   localparam int HOLD = 16;
   localparam int CORE = 4;

   logic       clk_in = 1'b0;
   logic       reset_in = 1'b0;
   logic       locked_in = 1'b0;
   logic       btn_pulse_in = 1'b0;
   logic       periph_reset_out;
   logic       core_reset_out;
   logic       reset_done_out;
   logic [1:0] cause_out;

   int checks = 0;
   int passes = 0;
   int fails  = 0;
   int step_no = 0;
   bit inv_on = 1'b0;

   // Model: age = edges since the sequence start (E0 or button edge), -1 while waiting for lock.
   int         age = -1;
   logic [1:0] m_cause = 2'b01;

   reset_sequencer #(
      .HOLD_CYCLES(HOLD),
      .CORE_DELAY (CORE)
   ) dut (
      .clk_in          (clk_in),
      .reset_in        (reset_in),
      .locked_in       (locked_in),
      .btn_pulse_in    (btn_pulse_in),
      .periph_reset_out(periph_reset_out),
      .core_reset_out  (core_reset_out),
      .reset_done_out  (reset_done_out),
      .cause_out       (cause_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, step_no, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic exp_periph, exp_core, exp_done;
      exp_periph = (age < HOLD);
      exp_core   = (age < HOLD + CORE);
      exp_done   = (age >= HOLD + CORE);
      check({tag, ".periph"}, {1'b0, periph_reset_out}, {1'b0, exp_periph});
      check({tag, ".core"},   {1'b0, core_reset_out},   {1'b0, exp_core});
      check({tag, ".done"},   {1'b0, reset_done_out},   {1'b0, exp_done});
      check({tag, ".cause"},  cause_out,                m_cause);
   endtask

   task automatic model_edge(input logic r, input logic lk, input logic bt);
      if (r) begin
         age = -1;
         m_cause = 2'b01;
      end else if (age < 0) begin
         if (lk) age = 0;
      end else if (!lk) begin
         age = -1;
         m_cause = 2'b10;
      end else if (bt) begin
         age = 0;
         m_cause = 2'b11;
      end else if (age < HOLD + CORE) begin
         age = age + 1;
      end
   endtask

   task automatic step(input string tag, input logic r, input logic lk, input logic bt);
      @(negedge clk_in);
      reset_in = r;
      locked_in = lk;
      btn_pulse_in = bt;
      @(posedge clk_in);
      model_edge(r, lk, bt);
      #1;
      step_no++;
      $display("%s step %0d rst=%0b lk=%0b btn=%0b periph=%0b core=%0b done=%0b cause=%0d",
               tag, step_no, r, lk, bt, periph_reset_out, core_reset_out,
               reset_done_out, cause_out);
      check_all(tag);
   endtask

   // Core must never leave reset while peripherals are still held.
   always @(negedge clk_in) begin
      if (inv_on) begin
         checks++;
         assert (!(core_reset_out === 1'b0 && periph_reset_out !== 1'b0)) passes++;
         else begin
            fails++;
            $error("FAIL invariant core=%0b periph=%0b required core=0 only with periph=0",
                   core_reset_out, periph_reset_out);
         end
      end
   end

   initial begin
      #2 reset_in = 1'b1;
      #1;
      check_all("por_async");
      inv_on = 1'b1;

      // Power-on: reset held, then lock arrives and the release sequence runs.
      for (int i = 0; i < 3; i++) step("por", 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) step("por_nolock", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 23; i++) step("por_lock", 1'b0, 1'b1, 1'b0);
      check("por_done_final", {1'b0, reset_done_out}, 2'b01);

      // Lock glitch during COUNT.
      step("glitch_rst", 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step("glitch_cnt", 1'b0, 1'b1, 1'b0);
      step("glitch_low", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 22; i++) step("glitch_relock", 1'b0, 1'b1, 1'b0);

      // Button press in RUN, then again two edges after periph release.
      step("btn_run", 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 17; i++) step("btn_run_seq", 1'b0, 1'b1, 1'b0);
      step("btn_periph", 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 22; i++) step("btn_periph_seq", 1'b0, 1'b1, 1'b0);

      // Lock loss together with button in RUN; button ignored in WAIT_LOCK.
      step("simul", 1'b0, 1'b0, 1'b1);
      step("wait_btn", 1'b0, 1'b0, 1'b1);
      step("wait_idle", 1'b0, 1'b0, 1'b0);
      step("wait_btn", 1'b0, 1'b0, 1'b1);
      check("simul_cause", cause_out, 2'b10);

      // Relock into PERIPH, then assert reset between edges.
      for (int i = 0; i < 18; i++) step("relock", 1'b0, 1'b1, 1'b0);
      @(negedge clk_in);
      #2 reset_in = 1'b1;
      model_edge(1'b1, 1'b0, 1'b0);
      #1;
      check_all("async_mid");
      step("async_hold", 1'b1, 1'b1, 1'b0);
      step("async_rel", 1'b0, 1'b1, 1'b0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         logic r, lk, bt;
         r  = ($urandom_range(0, 99) == 0);
         lk = ($urandom_range(0, 29) != 0);
         bt = ($urandom_range(0, 24) == 0);
         step("rand", r, lk, bt);
      end

      inv_on = 1'b0;
      #1;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
